// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_LAP   = 2'b10,
    ST_PAUSE = 2'b11
  } sw_state_e;

  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLEAR = 2;
  localparam int BTN_SPARE = 3;

  localparam int DIV_DEFAULT = 1000000;

  function automatic logic is_running(sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button input and control outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  // No handshake: btn is sampled every clock and every output is valid every clock.
  logic [3:0] btn;
  logic       tick;
  logic       clr;
  logic       freeze;
  logic       running;
  logic [1:0] state;

  modport master (output btn, input tick, clr, freeze, running, state);
  modport slave  (input btn, output tick, clr, freeze, running, state);
endinterface

// File: rtl/stopwatch_ctrl_tick_div.sv
// Centisecond divider: counts while enabled, holds otherwise, sync clear wins.
module tick_div #(
  parameter int DIV   = 4,
  parameter int DIV_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/lap/clear controller with button edge detect and tick divider.
// Build option: define STOPWATCH_LONG_CLEAR_EN to require a long hold on the clear button.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV         = DIV_DEFAULT,
  parameter int DIV_W       = 20,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic              clock,
  input  logic              reset,
  stopwatch_ctrl_if.slave   bus
);
  if (DIV < 2) begin : g_bad_div
    $error("DIV must be 2 or more");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be 2 or more");
  end

`ifdef STOPWATCH_LONG_CLEAR_EN
  localparam int EDGE_MSB = BTN_LAP;
`else
  localparam int EDGE_MSB = BTN_CLEAR;
`endif

  // Reset to all ones so a button held through reset is not seen as a press.
  logic [EDGE_MSB:0] btn_q;
  logic [EDGE_MSB:0] ev;
  logic              clear_ev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) btn_q <= '1;
    else       btn_q <= bus.btn[EDGE_MSB:0];
  end

  assign ev = bus.btn[EDGE_MSB:0] & ~btn_q;

`ifdef STOPWATCH_LONG_CLEAR_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Saturating one past the fire value keeps the clear event to a single cycle.
  always_comb begin
    hold_d = '0;
    if (bus.btn[BTN_CLEAR]) begin
      hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign clear_ev = bus.btn[BTN_CLEAR] && (hold_q == HOLD_FIRE);
`else
  assign clear_ev = ev[BTN_CLEAR];
`endif

  sw_state_e state_q, state_d;
  logic      clr_q, clr_d;
  logic      running;
  logic      freeze;
  logic      tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Each state checks only the events it honours, in priority order.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_ev)            clr_d   = 1'b1;
        else if (ev[BTN_START])  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ev[BTN_START])       state_d = ST_PAUSE;
        else if (ev[BTN_LAP])    state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ev[BTN_START])       state_d = ST_PAUSE;
        else if (ev[BTN_LAP])    state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (clear_ev) begin
          clr_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (ev[BTN_START]) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running = is_running(state_q);
    freeze  = (state_q == ST_LAP);
  end

  tick_div #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clock  (clock),
    .reset  (reset),
    .en_i   (running),
    .clr_i  (clr_d),
    .tick_o (tick)
  );

  assign bus.tick    = tick;
  assign bus.clr     = clr_q;
  assign bus.freeze  = freeze;
  assign bus.running = running;
  assign bus.state   = state_q;
endmodule
